// File: rtl/mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_master
// Description : Memory BIST initiator on the native memory bus. Writes a
//               per-word pattern, reads it back, writes the inverse and reads
//               that back, counting mismatching words and aborting on a
//               responder that never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [31:0] fail_addr,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_READ      = 3'd2,
    S_WRITE_INV = 3'd3,
    S_READ_INV  = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Word addresses are always aligned; the low two bits of the base are dropped.
  localparam logic [31:0] c_BASE     = {BASE_ADDR[31:2], 2'b00};
  localparam logic [15:0] c_LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_gap,   w_gap_nxt;    // 1 = idle cycle between transfers
  logic [15:0] r_idx,   w_idx_nxt;
  logic [15:0] r_wait,  w_wait_nxt;   // consecutive stalled request cycles
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_addr,  w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [3:0]  r_wstrb, w_wstrb_nxt;
  logic [15:0] r_err,   w_err_nxt;
  logic [31:0] r_fail,  w_fail_nxt;
  logic        r_tmo,   w_tmo_nxt;

  logic        w_load_req;
  logic        w_xfer;
  logic        w_is_read;
  logic        w_last;
  logic [31:0] w_expect;

  function automatic logic [31:0] f_pattern(input logic [15:0] idx);
    return {idx, ~idx};
  endfunction

  function automatic state_t f_next_phase(input state_t s);
    case (s)
      S_WRITE:     return S_READ;
      S_READ:      return S_WRITE_INV;
      S_WRITE_INV: return S_READ_INV;
      default:     return S_DONE;
    endcase
  endfunction

  // State and datapath registers; async reset forces an idle, silent bus.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_gap   <= 1'b0;
      r_idx   <= 16'd0;
      r_wait  <= 16'd0;
      r_valid <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_err   <= 16'd0;
      r_fail  <= 32'd0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_idx   <= w_idx_nxt;
      r_wait  <= w_wait_nxt;
      r_valid <= w_valid_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_wstrb <= w_wstrb_nxt;
      r_err   <= w_err_nxt;
      r_fail  <= w_fail_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Next-state logic: sequencing, compare, timeout and request launch.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_idx_nxt   = r_idx;
    w_wait_nxt  = r_wait;
    w_valid_nxt = r_valid;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wstrb_nxt = r_wstrb;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;
    w_tmo_nxt   = r_tmo;
    w_load_req  = 1'b0;
    w_xfer      = r_valid && mem_ready;
    w_is_read   = (r_state == S_READ) || (r_state == S_READ_INV);
    w_last      = (r_idx == c_LAST_IDX);
    w_expect    = (r_state == S_READ_INV) ? ~f_pattern(r_idx) : f_pattern(r_idx);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_err_nxt   = 16'd0;
          w_fail_nxt  = 32'd0;
          w_tmo_nxt   = 1'b0;
          w_state_nxt = S_WRITE;
          w_idx_nxt   = 16'd0;
          w_gap_nxt   = 1'b0;
          w_wait_nxt  = 16'd0;
          w_load_req  = 1'b1;
        end
      end
      S_WRITE, S_READ, S_WRITE_INV, S_READ_INV: begin
        if (r_gap) begin
          w_gap_nxt  = 1'b0;
          w_load_req = 1'b1;
        end else if (w_xfer) begin
          if (w_is_read && (mem_rdata != w_expect)) begin
            if (r_err != 16'hFFFF) w_err_nxt = r_err + 16'd1;
            // Only the first mismatch of a run is recorded.
            if (r_err == 16'd0) w_fail_nxt = r_addr;
          end
          w_wait_nxt  = 16'd0;
          w_valid_nxt = 1'b0;
          if (w_last) begin
            w_idx_nxt   = 16'd0;
            w_state_nxt = f_next_phase(r_state);
            w_gap_nxt   = (f_next_phase(r_state) != S_DONE);
          end else begin
            w_idx_nxt = r_idx + 16'd1;
            w_gap_nxt = 1'b1;
          end
        end else if (r_wait == c_TMO_LAST) begin
          // Responder stalled too long: abort and report the stuck address.
          w_valid_nxt = 1'b0;
          w_tmo_nxt   = 1'b1;
          w_fail_nxt  = r_addr;
          w_wait_nxt  = 16'd0;
          w_state_nxt = S_DONE;
        end else begin
          w_wait_nxt = r_wait + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_load_req) begin
      w_valid_nxt = 1'b1;
      w_addr_nxt  = c_BASE + {14'd0, w_idx_nxt, 2'b00};
      case (w_state_nxt)
        S_WRITE: begin
          w_wdata_nxt = f_pattern(w_idx_nxt);
          w_wstrb_nxt = 4'hF;
        end
        S_WRITE_INV: begin
          w_wdata_nxt = ~f_pattern(w_idx_nxt);
          w_wstrb_nxt = 4'hF;
        end
        default: begin
          w_wdata_nxt = 32'd0;
          w_wstrb_nxt = 4'h0;
        end
      endcase
    end
  end

  assign busy      = (r_state == S_WRITE) || (r_state == S_READ) ||
                     (r_state == S_WRITE_INV) || (r_state == S_READ_INV);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err == 16'd0) && !r_tmo;
  assign timeout   = r_tmo;
  assign err_count = r_err;
  assign fail_addr = r_fail;
  assign mem_valid = r_valid;
  assign mem_instr = 1'b0;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bist_master
// Description : Bench for mem_bist_master: a small memory responder plus a
//               transaction-level model of the expected run, compared every
//               cycle, with literal end-of-run expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bist_master;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          NW   = 4;
  localparam int          TMO  = 8;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] fail_addr;
  logic        mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'd0;

  mem_bist_master #(
    .BASE_ADDR(BASE),
    .NUM_WORDS(NW),
    .TIMEOUT  (TMO)
  ) u_dut (
    .clk      (clk),
    .reset_i  (reset_i),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          rd;
    logic [31:0] rexp;
  } xfer_t;

  // Expected-run model
  xfer_t       exp_q[$];
  bit          m_busy, m_done, m_gap, m_tmo;
  logic [15:0] m_err;
  logic [31:0] m_fail;
  int          m_wait;

  // Responder state and knobs
  logic [31:0] mem_arr [4];
  logic [31:0] addr_log [16];
  int          rx_cnt;
  bit          pend;
  bit          lat_mode, fault_en, hang_en;
  bit          start_req;

  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {v, ~v};
  endfunction

  // Whole run as an ordered list of transfers: four sweeps over the words.
  task automatic init_run();
    xfer_t e;
    exp_q.delete();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NW; i++) begin
        e.addr  = BASE + 32'(4 * i);
        e.rd    = (p == 1) || (p == 3);
        e.rexp  = (p == 1) ? pat(i) : ~pat(i);
        e.wdata = (p == 0) ? pat(i) : (p == 2) ? ~pat(i) : 32'd0;
        e.strb  = e.rd ? 4'h0 : 4'hF;
        exp_q.push_back(e);
      end
    end
    m_busy = 1; m_done = 0; m_gap = 0; m_tmo = 0;
    m_err = 0; m_fail = 0; m_wait = 0;
    rx_cnt = 0; pend = 0;
  endtask

  // One clock: check outputs, answer the bus, drive start, advance the model.
  task automatic tick();
    bit          rdy, exp_valid;
    logic [31:0] off, rd;
    xfer_t       e;
    @(negedge clk);
    if (reset_i) begin
      m_busy = 0; m_done = 0; m_gap = 0; m_tmo = 0;
      m_err = 0; m_fail = 0; m_wait = 0;
      exp_q.delete();
      rx_cnt = 0; pend = 0;
      start = 0;
      return;
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("mem_instr", mem_instr, 0);
    chk("err_count", err_count, m_err);
    chk("fail_addr", fail_addr, m_fail);
    chk("timeout", timeout, m_tmo);
    if (m_done) chk("pass", pass, (m_err == 0) && !m_tmo);
    exp_valid = m_busy && !m_gap;
    chk("mem_valid", mem_valid, exp_valid);
    if (exp_valid && mem_valid && exp_q.size() > 0) begin
      chk("mem_addr", mem_addr, exp_q[0].addr);
      chk("mem_wdata", mem_wdata, exp_q[0].wdata);
      chk("mem_wstrb", mem_wstrb, exp_q[0].strb);
    end

    if (!mem_valid) begin
      pend = 0;
      rdy  = !lat_mode;
    end else if (lat_mode) begin
      rdy  = pend;
      pend = !pend;
    end else begin
      rdy = !(hang_en && rx_cnt == 5);
    end
    off = mem_addr - BASE;
    rd  = (off[31:4] == 0) ? mem_arr[off[3:2]] : 32'd0;
    if (fault_en && off == 32'd8) rd[0] = 1'b0;
    if (mem_valid && rdy) begin
      if (mem_wstrb == 4'hF && off[31:4] == 0) mem_arr[off[3:2]] = mem_wdata;
      if (rx_cnt < 16) addr_log[rx_cnt] = mem_addr;
      rx_cnt++;
    end
    mem_ready = rdy;
    mem_rdata = rd;

    start     = start_req;
    start_req = 0;

    if (!m_busy) begin
      if (start) init_run();
    end else if (m_gap) begin
      m_gap = 0;
    end else if (rdy) begin
      e = exp_q.pop_front();
      if (e.rd && rd !== e.rexp) begin
        if (m_err == 0) m_fail = e.addr;
        if (m_err != 16'hFFFF) m_err++;
      end
      m_wait = 0;
      if (exp_q.size() == 0) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_gap = 1;
      end
    end else begin
      m_wait++;
      if (m_wait == TMO) begin
        m_busy = 0; m_done = 1; m_tmo = 1;
        m_fail = exp_q[0].addr;
        exp_q.delete();
      end
    end
  endtask

  task automatic launch();
    start_req = 1;
    tick();
    tick();
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400; k++) begin
      if (done) break;
      tick();
    end
    chk("run_finished", done, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem_arr[i] = 32'd0;
    for (int i = 0; i < 16; i++) addr_log[i] = 32'd0;
    lat_mode = 0; fault_en = 0; hang_en = 0; start_req = 0;

    // Power-on reset
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    @(posedge clk); #2 reset_i = 1'b0;
    repeat (3) tick();

    // Zero-wait responder: 16 transfers, clean pass
    launch();
    wait_done();
    tick();
    chk("zw_pass", pass, 1);
    chk("zw_err", err_count, 0);
    chk("zw_xfers", rx_cnt, 16);

    // Responder answering one cycle after each request
    lat_mode = 1;
    launch();
    wait_done();
    tick();
    chk("lat_pass", pass, 1);
    chk("lat_addr0", addr_log[0], 32'h100);
    chk("lat_addr3", addr_log[3], 32'h10C);
    chk("lat_addr4", addr_log[4], 32'h100);
    chk("lat_addr15", addr_log[15], 32'h10C);
    lat_mode = 0;

    // Bit 0 of word 2 stuck at 0: P(2) has LSB 1, so only one read fails
    fault_en = 1;
    launch();
    wait_done();
    tick();
    chk("flt_err", err_count, 1);
    chk("flt_fail_addr", fail_addr, 32'h108);
    chk("flt_pass", pass, 0);
    chk("flt_timeout", timeout, 0);
    fault_en = 0;

    // Responder never answers word 1 of the first read sweep
    hang_en = 1;
    launch();
    wait_done();
    tick();
    chk("hang_timeout", timeout, 1);
    chk("hang_fail_addr", fail_addr, 32'h104);
    chk("hang_pass", pass, 0);
    chk("hang_xfers", rx_cnt, 5);
    chk("hang_valid", mem_valid, 0);
    hang_en = 0;

    // Reset in the middle of the first write request
    launch();
    chk("pre_rst_valid", mem_valid, 1);
    #1 reset_i = 1'b1;
    #1;
    chk("mid_rst_valid", mem_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_wstrb", mem_wstrb, 0);
    chk("mid_rst_timeout", timeout, 0);
    tick();
    @(posedge clk); #2 reset_i = 1'b0;
    repeat (4) tick();

    // A start pulse while busy must not disturb the run
    launch();
    repeat (5) tick();
    start_req = 1;
    tick();
    wait_done();
    tick();
    chk("ign_xfers", rx_cnt, 16);
    chk("ign_pass", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
